// File: rtl/interval_timer_pkg.sv
// Shared types and elaboration helpers for the interval timer.
package interval_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of a counter that spans 0..div-1.
  function automatic int presc_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter; flags the cycle in which it wraps.
module tick_prescaler
  import interval_timer_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick_pulse
);

  localparam int PW = presc_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("tick_prescaler: DIV must be >= 2");
  end

  logic [PW-1:0] count;

  // The owner registers this, so the visible tick lands one cycle after the wrap.
  assign tick_pulse = !clear && !hold && (count == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (!hold)  count <= (count == LAST) ? '0 : count + PW'(1);
  end

endmodule

// File: rtl/interval_timer.sv
// Down-counting interval timer with prescaler, one-shot/periodic modes and pause.
// Define TIMER_WARN_EN to add the registered low-count warn output.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int CNT_W      = 9,
  parameter int WARN_LEVEL = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             pause,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_value,
  output logic             tick,
  output logic             done,
  output logic             expired,
  output logic             running,
  output logic [CNT_W-1:0] remaining
`ifdef TIMER_WARN_EN
  ,
  output logic             warn
`endif
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  if (DIV < 2) begin : g_div_chk
    $error("interval_timer: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (WARN_LEVEL < 0) begin : g_warn_chk
    $error("interval_timer: WARN_LEVEL must be non-negative");
  end

  timer_state_e     state, state_n;
  logic [CNT_W-1:0] reload, reload_n, remaining_n;
  logic             periodic_mode, periodic_n;
  logic             expired_n, done_n, tick_n, running_n;
  logic             presc_clear, presc_hold, wrap;

  // Prescaler also advances on the resume edge so paused time adds exactly once.
  assign presc_clear = !enable || start;
  assign presc_hold  = !((state == RUN || state == PAUSED) && !pause);

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clock      (clock),
    .reset      (reset),
    .clear      (presc_clear),
    .hold       (presc_hold),
    .tick_pulse (wrap)
  );

  always_comb begin
    state_n     = state;
    reload_n    = reload;
    remaining_n = remaining;
    periodic_n  = periodic_mode;
    expired_n   = expired;
    done_n      = 1'b0;
    tick_n      = 1'b0;
    if (!enable) begin
      state_n     = IDLE;
      reload_n    = '0;
      remaining_n = '0;
      periodic_n  = 1'b0;
      expired_n   = 1'b0;
    end else if (start) begin
      reload_n    = load_value;
      remaining_n = load_value;
      periodic_n  = periodic;
      expired_n   = 1'b0;
      state_n     = RUN;
      if (load_value == '0) begin
        done_n    = 1'b1;
        expired_n = 1'b1;
        state_n   = EXPIRED;
      end
    end else begin
      case (state)
        RUN:     if (pause)  state_n = PAUSED;
        PAUSED:  if (!pause) state_n = RUN;
        default: ;
      endcase
      if (wrap) begin
        tick_n = 1'b1;
        if (remaining == CNT_W'(1)) begin
          done_n = 1'b1;
          if (periodic_mode) begin
            remaining_n = reload;
          end else begin
            remaining_n = '0;
            expired_n   = 1'b1;
            state_n     = EXPIRED;
          end
        end else begin
          remaining_n = remaining - CNT_W'(1);
        end
      end
    end
  end

  assign running_n = (state_n == RUN) || (state_n == PAUSED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      reload        <= '0;
      periodic_mode <= 1'b0;
      remaining     <= '0;
      expired       <= 1'b0;
      done          <= 1'b0;
      tick          <= 1'b0;
      running       <= 1'b0;
    end else begin
      state         <= state_n;
      reload        <= reload_n;
      periodic_mode <= periodic_n;
      remaining     <= remaining_n;
      expired       <= expired_n;
      done          <= done_n;
      tick          <= tick_n;
      running       <= running_n;
    end
  end

`ifdef TIMER_WARN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) warn <= 1'b0;
    else        warn <= running_n && (int'(remaining_n) <= WARN_LEVEL) && (remaining_n != '0);
  end
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboarded random/directed bench for interval_timer (DIV=10, CNT_W=4).
module tb_interval_timer;

  localparam int DIV   = 10;
  localparam int CNT_W = 4;
  localparam int WL    = 5;
`ifdef TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  typedef struct {
    int cyc;
    int rem;
    bit tick;
    bit done;
    bit expired;
    bit running;
    bit warn;
  } ev_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             periodic = 1'b0;
  logic [CNT_W-1:0] load_value = '0;
  logic             tick, done, expired, running, warn_s;
  logic [CNT_W-1:0] remaining;

  interval_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(CNT_W), .WARN_LEVEL(WL)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .pause      (pause),
    .periodic   (periodic),
    .load_value (load_value),
    .tick       (tick),
    .done       (done),
    .expired    (expired),
    .running    (running),
    .remaining  (remaining)
`ifdef TIMER_WARN_EN
    ,
    .warn       (warn_s)
`endif
  );
`ifndef TIMER_WARN_EN
  assign warn_s = 1'b0;
`endif

  always #5 clock = ~clock;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t q[$];
  ev_t ev;

  // Reference run description: start edge, count, mode, pause window (edges s+a .. s+a+l-1).
  int  m_s, m_n, m_a, m_l;
  bit  m_per;
  bit  m_active = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic bit exp_warn(bit rn, int rm);
    return WARN_ON && rn && (rm <= WL) && (rm != 0);
  endfunction

  function automatic void push_ev(int c, bit tk, bit dn, bit ex, bit rn, int rm);
    ev_t e;
    e.cyc = c; e.tick = tk; e.done = dn; e.expired = ex; e.running = rn; e.rem = rm;
    e.warn = exp_warn(rn, rm);
    q.push_back(e);
  endfunction

  function automatic void flush_from(int c);
    while (q.size() > 0 && q[q.size()-1].cyc >= c) void'(q.pop_back());
  endfunction

  function automatic int shifted(int t);
    return (m_l > 0 && t >= m_a) ? t + m_l : t;
  endfunction

  function automatic int overlap(int c);
    int lo, hi;
    if (m_l == 0) return 0;
    lo = m_s + m_a;
    hi = m_s + m_a + m_l - 1;
    if (c < lo) return 0;
    return ((c < hi) ? c : hi) - lo + 1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue a start on the next edge and queue every tick/done expected up to s+horizon.
  task automatic launch(int n, bit per, int a, int l, int horizon);
    int s;
    s = cyc + 1;
    flush_from(s);
    m_s = s; m_n = n; m_per = per; m_a = a; m_l = l; m_active = 1'b1;
    if (n == 0) begin
      push_ev(s, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    end else begin
      for (int i = 1; i <= 64; i++) begin
        int  j, c;
        bit  last;
        j    = (i - 1) % n + 1;
        c    = s + shifted(i * DIV);
        last = (j == n);
        if (c > s + horizon) break;
        push_ev(c, 1'b1, last, last && !per, !(last && !per), last ? (per ? n : 0) : n - j);
        if (last && !per) break;
      end
    end
    start = 1'b1; load_value = CNT_W'(n); periodic = per;
    step();
    start = 1'b0;
  endtask

  task automatic advance(int rel);
    while (cyc < m_s + rel) begin
      if (m_l > 0 && cyc == m_s + m_a - 1)       pause = 1'b1;
      if (m_l > 0 && cyc == m_s + m_a + m_l - 1) pause = 1'b0;
      step();
    end
  endtask

  task automatic check_status(string name);
    int e, ticks, rm;
    bit rn, ex;
    if (!m_active) begin
      rm = 0; rn = 0; ex = 0;
    end else if (m_n == 0) begin
      rm = 0; rn = 0; ex = 1;
    end else begin
      e     = (cyc - m_s) - overlap(cyc);
      ticks = e / DIV;
      if (m_per)              begin rm = m_n - ticks % m_n; rn = 1; ex = 0; end
      else if (ticks >= m_n)  begin rm = 0;                 rn = 0; ex = 1; end
      else                    begin rm = m_n - ticks;       rn = 1; ex = 0; end
    end
    checks++;
    if (remaining !== CNT_W'(rm) || running !== rn || expired !== ex || warn_s !== exp_warn(rn, rm)) begin
      failures++;
      $display("FAIL %s cyc=%0d: got rem=%0d run=%0b exp=%0b warn=%0b, want rem=%0d run=%0b exp=%0b warn=%0b",
               name, cyc, remaining, running, expired, warn_s, rm, rn, ex, exp_warn(rn, rm));
    end
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({tick, done, expired, running, warn_s} !== 5'b0 || remaining !== '0) begin
      failures++;
      $display("FAIL %s: got tick=%0b done=%0b exp=%0b run=%0b warn=%0b rem=%0d, want all 0",
               name, tick, done, expired, running, warn_s, remaining);
    end
  endtask

  task automatic drop_enable(string name);
    enable = 1'b0;
    flush_from(cyc + 1);
    step();
    m_active = 1'b0;
    check_zero(name);
    enable = 1'b1;
  endtask

  // Monitor: every tick/done the DUT shows must match the head of the scoreboard.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; failures++;
      $display("FAIL missing_event cyc=%0d: got no tick/done, want one at cyc %0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (tick || done) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d: got tick=%0b done=%0b rem=%0d, want none", cyc, tick, done, remaining);
      end else begin
        ev = q.pop_front();
        if (tick !== ev.tick || done !== ev.done || remaining !== CNT_W'(ev.rem) ||
            expired !== ev.expired || running !== ev.running || warn_s !== ev.warn) begin
          failures++;
          $display("FAIL event cyc=%0d: got tick=%0b done=%0b rem=%0d exp=%0b run=%0b warn=%0b, want tick=%0b done=%0b rem=%0d exp=%0b run=%0b warn=%0b",
                   cyc, tick, done, remaining, expired, running, warn_s,
                   ev.tick, ev.done, ev.rem, ev.expired, ev.running, ev.warn);
        end
      end
    end
  end

  initial begin
    repeat (3) step();
    check_zero("reset_state");
    reset = 1'b1; enable = 1'b1;
    step();
    check_zero("idle_after_reset");

    // One-shot N=3, then pause in EXPIRED must be ignored.
    launch(3, 1'b0, 0, 0, 40);
    advance(34);
    check_status("oneshot_end");
    pause = 1'b1; step(); step(); pause = 1'b0; step();
    check_status("pause_ignored_expired");

    // Periodic N=2 over three periods.
    launch(2, 1'b1, 0, 0, 65);
    advance(65);
    check_status("periodic_run");
    drop_enable("periodic_stop");

    // Pause across edges 15..21: done slips to 27.
    launch(2, 1'b0, 15, 7, 40);
    advance(18);
    check_status("paused_hold");
    advance(32);
    check_status("pause_done");

    // enable low at cycle 12.
    launch(3, 1'b0, 0, 0, 40);
    advance(11);
    drop_enable("enable_low");
    repeat (25) step();
    check_status("idle_stays");

    // Zero load expires immediately regardless of mode.
    launch(0, 1'b1, 0, 0, 5);
    advance(3);
    check_status("zero_load");

    // Restart at cycle 25 discards the old count.
    launch(3, 1'b0, 0, 0, 40);
    advance(24);
    launch(2, 1'b0, 0, 0, 30);
    advance(25);
    check_status("restart_end");

    // Asynchronous reset between edges.
    launch(3, 1'b0, 0, 0, 40);
    advance(14);
    #2 reset = 1'b0;
    q.delete();
    m_active = 1'b0;
    #1 check_zero("async_reset");
    step(); step();
    reset = 1'b1;
    step();
    launch(1, 1'b0, 0, 0, 15);
    advance(15);
    check_status("after_reset");

    // Warn window sweep.
    launch(8, 1'b0, 0, 0, 90);
    advance(85);
    check_status("warn_run");

    for (int it = 0; it < 14; it++) begin
      int n, a, l, rc;
      bit per;
      n   = int'($urandom_range(0, 15));
      per = 1'($urandom_range(0, 1));
      a   = 0;
      l   = 0;
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(1, n * DIV - 1));
        l = int'($urandom_range(1, 12));
      end
      rc = per ? (2 * n * DIV + l + int'($urandom_range(0, 15)))
               : (n * DIV + l + int'($urandom_range(2, 6)));
      launch(n, per, a, l, rc);
      advance(rc);
      check_status("rand_end");
      if ($urandom_range(0, 1) == 1) drop_enable("rand_disable");
    end

    drop_enable("final_idle");
    repeat (3) step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
